// File: rtl/gnn_pkg.sv
// Shared types, width helpers and default adjacency for the sequential GNN layer engine.
package gnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AGG  = 2'd1,
        ST_MAC  = 2'd2,
        ST_DONE = 2'd3
    } gnn_state_e;

    // Ring on four nodes: bit n*4+m set means node n aggregates node m.
    localparam logic [15:0] GNN_ADJ_RING4 = 16'h6996;

    function automatic int unsigned agg_w(input int unsigned xw, input int unsigned n);
        return xw + $clog2(n + 1);
    endfunction

    function automatic int unsigned out_w(input int unsigned xw, input int unsigned ww,
                                          input int unsigned n, input int unsigned f);
        return agg_w(xw, n) + ww + $clog2(f + 1);
    endfunction

endpackage

// File: rtl/gnn_mac.sv
// Shared signed multiply-accumulate with end-of-dot-product clear and ReLU on the result path.
module gnn_mac #(
    parameter int unsigned AW = 8,
    parameter int unsigned WW = 5,
    parameter int unsigned YW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 last,
    input  logic                 relu_en,
    input  logic signed [AW-1:0] a,
    input  logic signed [WW-1:0] b,
    output logic signed [YW-1:0] result_c
);

    logic signed [AW+WW-1:0] prod_c;
    logic signed [YW-1:0]    acc_q;
    logic signed [YW-1:0]    sum_c;

    assign prod_c   = a * b;
    assign sum_c    = acc_q + YW'(prod_c);
    assign result_c = (relu_en && sum_c[YW-1]) ? '0 : sum_c;

    // Accumulator restarts after each completed dot product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= last ? '0 : sum_c;
        end
    end

endmodule

// File: rtl/gnn_layer_seq.sv
// Time-multiplexed GNN layer: capture graph, aggregate neighbours per node, then one shared MAC for the dense transform.
module gnn_layer_seq
    import gnn_pkg::*;
#(
    parameter  int unsigned N_NODES = 4,
    parameter  int unsigned N_FEAT  = 4,
    parameter  int unsigned N_OUT   = 2,
    parameter  int unsigned XW      = 5,
    parameter  int unsigned WW      = 5,
    localparam int unsigned AW      = agg_w(XW, N_NODES),
    localparam int unsigned YW      = out_w(XW, WW, N_NODES, N_FEAT)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [N_NODES*N_FEAT*XW-1:0]     x_flat,
    input  logic [N_FEAT*N_OUT*WW-1:0]       w_flat,
    input  logic [N_NODES*N_NODES-1:0]       adj,
    input  logic                             relu_en,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [N_NODES*N_OUT*YW-1:0]      y_flat,
    output logic                             busy
);

    localparam int unsigned NW = (N_NODES > 1) ? $clog2(N_NODES) : 1;
    localparam int unsigned FW = (N_FEAT  > 1) ? $clog2(N_FEAT)  : 1;
    localparam int unsigned OW = (N_OUT   > 1) ? $clog2(N_OUT)   : 1;

    gnn_state_e state_q, state_d;

    logic signed [XW-1:0] x_q   [N_NODES][N_FEAT];
    logic signed [WW-1:0] w_q   [N_FEAT][N_OUT];
    logic [N_NODES-1:0]   adj_q [N_NODES];
    logic                 relu_q;

    logic signed [AW-1:0] agg_q [N_NODES][N_FEAT];
    logic signed [AW-1:0] agg_c [N_FEAT];
    logic signed [YW-1:0] y_q   [N_NODES][N_OUT];

    logic [NW-1:0] n_q;
    logic [OW-1:0] o_q;
    logic [FW-1:0] f_q;
    logic          n_last_c, o_last_c, f_last_c;
    logic          accept_c, mac_en_c;

    logic signed [AW-1:0] mac_a_c;
    logic signed [WW-1:0] mac_b_c;
    logic signed [YW-1:0] mac_y_c;

    assign accept_c = in_valid && in_ready;
    assign n_last_c = (n_q == NW'(N_NODES - 1));
    assign o_last_c = (o_q == OW'(N_OUT - 1));
    assign f_last_c = (f_q == FW'(N_FEAT - 1));
    assign mac_en_c = (state_q == ST_MAC);
    assign mac_a_c  = agg_q[n_q][f_q];
    assign mac_b_c  = w_q[f_q][o_q];

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept_c)                         state_d = ST_AGG;
            ST_AGG:  if (n_last_c)                         state_d = ST_MAC;
            ST_MAC:  if (n_last_c && o_last_c && f_last_c) state_d = ST_DONE;
            ST_DONE: if (out_ready)                        state_d = ST_IDLE;
            default:                                       state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == ST_IDLE);
            out_valid <= (state_d == ST_DONE);
            busy      <= (state_d == ST_AGG) || (state_d == ST_MAC);
        end
    end

    // Self term plus every flagged neighbour for the node currently addressed.
    always_comb begin
        for (int f = 0; f < N_FEAT; f++) begin
            agg_c[f] = AW'(x_q[n_q][f]);
            for (int m = 0; m < N_NODES; m++) begin
                if ((NW'(m) != n_q) && adj_q[n_q][m]) begin
                    agg_c[f] = agg_c[f] + AW'(x_q[m][f]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < N_NODES; n++) begin
                adj_q[n] <= '0;
                for (int f = 0; f < N_FEAT; f++) begin
                    x_q[n][f]   <= '0;
                    agg_q[n][f] <= '0;
                end
                for (int o = 0; o < N_OUT; o++) y_q[n][o] <= '0;
            end
            for (int f = 0; f < N_FEAT; f++)
                for (int o = 0; o < N_OUT; o++) w_q[f][o] <= '0;
            relu_q <= 1'b0;
            n_q    <= '0;
            o_q    <= '0;
            f_q    <= '0;
        end else begin
            if (state_q == ST_IDLE && accept_c) begin
                for (int n = 0; n < N_NODES; n++) begin
                    adj_q[n] <= adj[n*N_NODES +: N_NODES];
                    for (int f = 0; f < N_FEAT; f++)
                        x_q[n][f] <= x_flat[(n*N_FEAT + f)*XW +: XW];
                end
                for (int f = 0; f < N_FEAT; f++)
                    for (int o = 0; o < N_OUT; o++)
                        w_q[f][o] <= w_flat[(f*N_OUT + o)*WW +: WW];
                relu_q <= relu_en;
                n_q    <= '0;
                o_q    <= '0;
                f_q    <= '0;
            end else if (state_q == ST_AGG) begin
                for (int f = 0; f < N_FEAT; f++) agg_q[n_q][f] <= agg_c[f];
                n_q <= n_last_c ? '0 : n_q + NW'(1);
            end else if (state_q == ST_MAC) begin
                // Feature is the inner loop, then output, then node.
                if (f_last_c) begin
                    y_q[n_q][o_q] <= mac_y_c;
                    f_q <= '0;
                    if (o_last_c) begin
                        o_q <= '0;
                        n_q <= n_last_c ? '0 : n_q + NW'(1);
                    end else begin
                        o_q <= o_q + OW'(1);
                    end
                end else begin
                    f_q <= f_q + FW'(1);
                end
            end
        end
    end

    gnn_mac #(
        .AW (AW),
        .WW (WW),
        .YW (YW)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (accept_c),
        .en       (mac_en_c),
        .last     (f_last_c),
        .relu_en  (relu_q),
        .a        (mac_a_c),
        .b        (mac_b_c),
        .result_c (mac_y_c)
    );

    for (genvar n = 0; n < N_NODES; n++) begin : g_y_node
        for (genvar o = 0; o < N_OUT; o++) begin : g_y_out
            assign y_flat[(n*N_OUT + o)*YW +: YW] = y_q[n][o];
        end
    end

endmodule

// File: tb/tb_gnn_layer_seq.sv
// Randomised self-checking bench for gnn_layer_seq at default and swept parameters against a plain-arithmetic model.
module tb_gnn_layer_seq;
    import gnn_pkg::*;

    localparam int unsigned XW = 5;
    localparam int unsigned WW = 5;
    localparam int unsigned NA = 4, FA = 4, OA = 2;
    localparam int unsigned NB = 6, FB = 3, OB = 3;
    localparam int unsigned YA = out_w(XW, WW, NA, FA);
    localparam int unsigned YB = out_w(XW, WW, NB, FB);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                  in_valid_a, in_ready_a, relu_a, out_valid_a, out_ready_a, busy_a;
    logic [NA*FA*XW-1:0]   x_a;
    logic [FA*OA*WW-1:0]   w_a;
    logic [NA*NA-1:0]      adj_a;
    logic [NA*OA*YA-1:0]   y_a;

    logic                  in_valid_b, in_ready_b, relu_b, out_valid_b, out_ready_b, busy_b;
    logic [NB*FB*XW-1:0]   x_b;
    logic [FB*OB*WW-1:0]   w_b;
    logic [NB*NB-1:0]      adj_b;
    logic [NB*OB*YB-1:0]   y_b;

    gnn_layer_seq #(.N_NODES(NA), .N_FEAT(FA), .N_OUT(OA), .XW(XW), .WW(WW)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .x_flat(x_a), .w_flat(w_a), .adj(adj_a), .relu_en(relu_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .y_flat(y_a), .busy(busy_a)
    );

    gnn_layer_seq #(.N_NODES(NB), .N_FEAT(FB), .N_OUT(OB), .XW(XW), .WW(WW)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .x_flat(x_b), .w_flat(w_b), .adj(adj_b), .relu_en(relu_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .y_flat(y_b), .busy(busy_b)
    );

    int checks = 0;
    int errors = 0;

    int     xm   [6][4];
    int     wm   [4][3];
    bit     adjm [6][6];
    longint ym   [6][3];

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: aggregate (self plus flagged neighbours), dense transform, optional clamp.
    task automatic model(input int nn, input int ff, input int oo, input bit relu);
        for (int n = 0; n < nn; n++) begin
            for (int o = 0; o < oo; o++) begin
                longint s = 0;
                for (int f = 0; f < ff; f++) begin
                    longint a = xm[n][f];
                    for (int m = 0; m < nn; m++)
                        if (m != n && adjm[n][m]) a += xm[m][f];
                    s += a * wm[f][o];
                end
                if (relu && s < 0) s = 0;
                ym[n][o] = s;
            end
        end
    endtask

    task automatic fill_const(input int xv, input int wv, input logic [15:0] adjv);
        for (int n = 0; n < 4; n++) begin
            for (int f = 0; f < 4; f++) xm[n][f] = xv;
            for (int m = 0; m < 4; m++) adjm[n][m] = adjv[n*4 + m];
        end
        for (int f = 0; f < 4; f++)
            for (int o = 0; o < 3; o++) wm[f][o] = wv;
    endtask

    task automatic fill_rand(input int nn);
        for (int n = 0; n < 6; n++) begin
            for (int f = 0; f < 4; f++) xm[n][f] = int'($urandom_range(0, 31)) - 16;
            for (int m = 0; m < 6; m++) adjm[n][m] = (m < nn) ? bit'($urandom_range(0, 1)) : 1'b0;
        end
        for (int f = 0; f < 4; f++)
            for (int o = 0; o < 3; o++) wm[f][o] = int'($urandom_range(0, 31)) - 16;
    endtask

    task automatic drive_a(input bit relu);
        for (int n = 0; n < int'(NA); n++) begin
            for (int f = 0; f < int'(FA); f++) x_a[(n*FA + f)*XW +: XW] = XW'(xm[n][f]);
            for (int m = 0; m < int'(NA); m++) adj_a[n*NA + m] = adjm[n][m];
        end
        for (int f = 0; f < int'(FA); f++)
            for (int o = 0; o < int'(OA); o++) w_a[(f*OA + o)*WW +: WW] = WW'(wm[f][o]);
        relu_a = relu;
    endtask

    task automatic accept_a();
        check("a_ready_idle", longint'(in_ready_a), 1);
        in_valid_a = 1'b1;
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        check("a_busy_after_accept", longint'(busy_a), 1);
        check("a_ready_after_accept", longint'(in_ready_a), 0);
    endtask

    task automatic check_y_a(input string tag);
        for (int n = 0; n < int'(NA); n++)
            for (int o = 0; o < int'(OA); o++)
                check(tag, longint'($signed(y_a[(n*OA + o)*YA +: YA])), ym[n][o]);
    endtask

    // One full transaction on the default instance, optionally stalling the result for hold cycles.
    task automatic run_a(input bit relu, input int hold);
        int cyc = 0;
        drive_a(relu);
        model(NA, FA, OA, relu);
        accept_a();
        while (!out_valid_a && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("a_latency", cyc, NA + NA*OA*FA);
        check_y_a("a_y");
        for (int k = 0; k < hold; k++) begin
            in_valid_a = k[0];
            x_a = ~x_a;
            w_a = ~w_a;
            @(posedge clk); #1;
            check("a_hold_valid", longint'(out_valid_a), 1);
            check("a_hold_ready", longint'(in_ready_a), 0);
            check_y_a("a_hold_y");
        end
        in_valid_a = 1'b0;
        out_ready_a = 1'b1;
        @(posedge clk); #1;
        out_ready_a = 1'b0;
        check("a_valid_after_hs", longint'(out_valid_a), 0);
        check("a_ready_after_hs", longint'(in_ready_a), 1);
        check("a_busy_after_hs", longint'(busy_a), 0);
    endtask

    task automatic run_b(input bit relu);
        int cyc = 0;
        for (int n = 0; n < int'(NB); n++) begin
            for (int f = 0; f < int'(FB); f++) x_b[(n*FB + f)*XW +: XW] = XW'(xm[n][f]);
            for (int m = 0; m < int'(NB); m++) adj_b[n*NB + m] = adjm[n][m];
        end
        for (int f = 0; f < int'(FB); f++)
            for (int o = 0; o < int'(OB); o++) w_b[(f*OB + o)*WW +: WW] = WW'(wm[f][o]);
        relu_b = relu;
        model(NB, FB, OB, relu);
        check("b_ready_idle", longint'(in_ready_b), 1);
        in_valid_b = 1'b1;
        @(posedge clk); #1;
        in_valid_b = 1'b0;
        while (!out_valid_b && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("b_latency", cyc, NB + NB*OB*FB);
        for (int n = 0; n < int'(NB); n++)
            for (int o = 0; o < int'(OB); o++)
                check("b_y", longint'($signed(y_b[(n*OB + o)*YB +: YB])), ym[n][o]);
        out_ready_b = 1'b1;
        @(posedge clk); #1;
        out_ready_b = 1'b0;
        check("b_ready_after_hs", longint'(in_ready_b), 1);
    endtask

    initial begin
        in_valid_a = 1'b0; out_ready_a = 1'b0; relu_a = 1'b0;
        x_a = '0; w_a = '0; adj_a = '0;
        in_valid_b = 1'b0; out_ready_b = 1'b0; relu_b = 1'b0;
        x_b = '0; w_b = '0; adj_b = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", longint'(in_ready_a), 1);
        check("rst_valid", longint'(out_valid_a), 0);
        check("rst_busy", longint'(busy_a), 0);
        check("rst_y_zero", longint'(y_a == '0), 1);
        check("rst_b_ready", longint'(in_ready_b), 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Ring graph, unit data: every node sums three ones over four features.
        fill_const(1, 1, GNN_ADJ_RING4);
        run_a(1'b0, 0);
        check("ring_y0_const", longint'($signed(y_a[YA-1:0])), 12);

        fill_const(1, -1, GNN_ADJ_RING4);
        run_a(1'b0, 0);
        check("ring_neg_const", longint'($signed(y_a[YA-1:0])), -12);
        run_a(1'b1, 0);
        check("ring_relu_const", longint'($signed(y_a[YA-1:0])), 0);

        // Most negative operands with full adjacency, then self-only.
        fill_const(-16, -16, 16'hFFFF);
        run_a(1'b0, 0);
        check("extreme_const", longint'($signed(y_a[(NA*OA-1)*YA +: YA])), 4096);
        fill_const(1, 1, 16'h0000);
        run_a(1'b0, 0);
        check("self_only_const", longint'($signed(y_a[YA-1:0])), 4);

        // Back-pressure in DONE with in_valid pulses and changing inputs.
        fill_rand(NA);
        run_a(1'($urandom_range(0, 1)), 10);

        // Reset during MAC aborts the transaction.
        fill_rand(NA);
        drive_a(1'b0);
        accept_a();
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", longint'(out_valid_a), 0);
        check("midrst_ready", longint'(in_ready_a), 1);
        check("midrst_busy", longint'(busy_a), 0);
        check("midrst_y_zero", longint'(y_a == '0), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        fill_const(1, 1, GNN_ADJ_RING4);
        run_a(1'b0, 0);

        for (int t = 0; t < 6; t++) begin
            fill_rand(NA);
            run_a(1'($urandom_range(0, 1)), 0);
        end

        for (int t = 0; t < 6; t++) begin
            fill_rand(NB);
            run_b(1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
